alu_issue_ctrl: RTL and testbench

Sequencing front end that initiates operations on the combinational `alu`. It accepts operation requests over a valid/ready handshake and registers the opcode and operands onto the ALU ports. It holds those ports stable for a per-opcode number of cycles, which provides the multicycle path needed for multiply and divide. It then captures the result and flags into a response register that is returned over a second valid/ready handshake. It sits between the execute-stage issue logic and the `alu` instance in the datapath.

---
 rtl/alu_pkg.sv | 37 +++
 rtl/alu_op_latency.sv | 25 ++
 rtl/alu_issue_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg
// Shared definitions for the ALU datapath: opcode constants, the highest
// legal opcode, the issue-controller counter width and FSM state encoding.
// No ports; imported by alu_op_latency and alu_issue_ctrl.
package alu_pkg;

    localparam logic [3:0] ALU_SLL    = 4'd0;
    localparam logic [3:0] ALU_SRA    = 4'd1;
    localparam logic [3:0] ALU_SRL    = 4'd2;
    localparam logic [3:0] ALU_MUL    = 4'd3;
    localparam logic [3:0] ALU_DIV    = 4'd4;
    localparam logic [3:0] ALU_ADD    = 4'd5;
    localparam logic [3:0] ALU_SUB    = 4'd6;
    localparam logic [3:0] ALU_AND    = 4'd7;
    localparam logic [3:0] ALU_OR     = 4'd8;
    localparam logic [3:0] ALU_XOR    = 4'd9;
    localparam logic [3:0] ALU_NOR    = 4'd10;
    localparam logic [3:0] ALU_SLT    = 4'd11;
    localparam logic [3:0] ALU_SLTU   = 4'd12;

    localparam logic [3:0] ALU_OP_MAX = 4'd12;

    // Exec down-counter width; holds N-1 for N up to 16.
    localparam int CNT_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } issue_state_e;

    // Opcodes above ALU_OP_MAX have no ALU function behind them.
    function automatic logic op_is_illegal(input logic [3:0] op);
        return op > ALU_OP_MAX;
    endfunction

endpackage

// File: rtl/alu_op_latency.sv
// alu_op_latency
// Combinational map from ALU opcode to (exec cycles - 1), used to preload
// the issue controller's down-counter.
//   op      in  4          opcode being accepted
//   lat_m1  out CNT_WIDTH  number of exec cycles minus one
module alu_op_latency
    import alu_pkg::*;
#(
    parameter int MUL_CYCLES = 2,
    parameter int DIV_CYCLES = 4
) (
    input  logic [3:0]           op,
    output logic [CNT_WIDTH-1:0] lat_m1
);

    always_comb begin
        lat_m1 = '0;
        case (op)
            ALU_MUL: lat_m1 = CNT_WIDTH'(MUL_CYCLES - 1);
            ALU_DIV: lat_m1 = CNT_WIDTH'(DIV_CYCLES - 1);
            default: lat_m1 = '0;
        endcase
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl
// Issue front end for the combinational ALU. Accepts a request over
// req_valid/req_ready, registers opcode and operands onto the ALU ports,
// holds them for the opcode's exec length, then captures result and flags
// into a response register returned over rsp_valid/rsp_ready.
//   clk, rst_n                         clock, async active-low reset
//   req_valid/req_ready                request handshake
//   req_op, req_a, req_b, req_tag      request payload
//   alu_op, alu_a, alu_b               registered ALU inputs
//   alu_out, alu_zero, alu_of, alu_uof ALU result and flags
//   rsp_valid/rsp_ready                response handshake
//   rsp_data, rsp_zero/of/uof          captured result and flags
//   rsp_dz, rsp_illegal, rsp_tag       divide-by-zero, bad opcode, request tag
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 4,
    parameter int MUL_CYCLES = 2,
    parameter int DIV_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [3:0]            req_op,
    input  logic [DATA_WIDTH-1:0] req_a,
    input  logic [DATA_WIDTH-1:0] req_b,
    input  logic [TAG_WIDTH-1:0]  req_tag,
    output logic [3:0]            alu_op,
    output logic [DATA_WIDTH-1:0] alu_a,
    output logic [DATA_WIDTH-1:0] alu_b,
    input  logic [DATA_WIDTH-1:0] alu_out,
    input  logic                  alu_zero,
    input  logic                  alu_of,
    input  logic                  alu_uof,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  rsp_zero,
    output logic                  rsp_of,
    output logic                  rsp_uof,
    output logic                  rsp_dz,
    output logic                  rsp_illegal,
    output logic [TAG_WIDTH-1:0]  rsp_tag
);

    issue_state_e          state_q, state_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [3:0]            alu_op_q, alu_op_d;
    logic [DATA_WIDTH-1:0] alu_a_q, alu_a_d;
    logic [DATA_WIDTH-1:0] alu_b_q, alu_b_d;
    logic [TAG_WIDTH-1:0]  tag_q, tag_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic                  rsp_zero_q, rsp_zero_d;
    logic                  rsp_of_q, rsp_of_d;
    logic                  rsp_uof_q, rsp_uof_d;
    logic                  rsp_dz_q, rsp_dz_d;
    logic                  rsp_illegal_q, rsp_illegal_d;
    logic [TAG_WIDTH-1:0]  rsp_tag_q, rsp_tag_d;

    logic [CNT_WIDTH-1:0]  lat_m1;
    logic                  accept;

    alu_op_latency #(
        .MUL_CYCLES (MUL_CYCLES),
        .DIV_CYCLES (DIV_CYCLES)
    ) u_latency (
        .op     (req_op),
        .lat_m1 (lat_m1)
    );

    // A response slot frees up in the same cycle it is consumed, which gives
    // back-to-back issue at one single-cycle op every two cycles.
    assign req_ready = rst_n && ((state_q == ST_IDLE) ||
                                 ((state_q == ST_RESP) && rsp_ready));
    assign accept    = req_valid && req_ready;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        alu_op_d      = alu_op_q;
        alu_a_d       = alu_a_q;
        alu_b_d       = alu_b_q;
        tag_d         = tag_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_data_d    = rsp_data_q;
        rsp_zero_d    = rsp_zero_q;
        rsp_of_d      = rsp_of_q;
        rsp_uof_d     = rsp_uof_q;
        rsp_dz_d      = rsp_dz_q;
        rsp_illegal_d = rsp_illegal_q;
        rsp_tag_d     = rsp_tag_q;

        case (state_q)
            ST_EXEC: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    // ALU inputs have now been stable for the full exec length.
                    state_d     = ST_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_tag_d   = tag_q;
                    if (op_is_illegal(alu_op_q)) begin
                        rsp_data_d    = '0;
                        rsp_zero_d    = 1'b0;
                        rsp_of_d      = 1'b0;
                        rsp_uof_d     = 1'b0;
                        rsp_dz_d      = 1'b0;
                        rsp_illegal_d = 1'b1;
                    end else begin
                        rsp_zero_d    = alu_zero;
                        rsp_of_d      = alu_of;
                        rsp_uof_d     = alu_uof;
                        rsp_illegal_d = 1'b0;
                        rsp_dz_d      = (alu_op_q == ALU_DIV) && (alu_b_q == '0);
                        rsp_data_d    = rsp_dz_d ? '0 : alu_out;
                    end
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // accept only happens in IDLE or in RESP while the response drains,
        // so it may override whatever the state decode chose.
        if (accept) begin
            alu_op_d = req_op;
            alu_a_d  = req_a;
            alu_b_d  = req_b;
            tag_d    = req_tag;
            cnt_d    = lat_m1;
            state_d  = ST_EXEC;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            alu_op_q      <= '0;
            alu_a_q       <= '0;
            alu_b_q       <= '0;
            tag_q         <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_data_q    <= '0;
            rsp_zero_q    <= 1'b0;
            rsp_of_q      <= 1'b0;
            rsp_uof_q     <= 1'b0;
            rsp_dz_q      <= 1'b0;
            rsp_illegal_q <= 1'b0;
            rsp_tag_q     <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            alu_op_q      <= alu_op_d;
            alu_a_q       <= alu_a_d;
            alu_b_q       <= alu_b_d;
            tag_q         <= tag_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_data_q    <= rsp_data_d;
            rsp_zero_q    <= rsp_zero_d;
            rsp_of_q      <= rsp_of_d;
            rsp_uof_q     <= rsp_uof_d;
            rsp_dz_q      <= rsp_dz_d;
            rsp_illegal_q <= rsp_illegal_d;
            rsp_tag_q     <= rsp_tag_d;
        end
    end

    assign alu_op      = alu_op_q;
    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_zero    = rsp_zero_q;
    assign rsp_of      = rsp_of_q;
    assign rsp_uof     = rsp_uof_q;
    assign rsp_dz      = rsp_dz_q;
    assign rsp_illegal = rsp_illegal_q;
    assign rsp_tag     = rsp_tag_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl
// Bench for alu_issue_ctrl with a behavioural ALU hooked to the ALU ports
// and an expected-response model built from the request alone.
module tb_alu_issue_ctrl;

    localparam int DW    = 32;
    localparam int TW    = 4;
    localparam int MUL_C = 2;
    localparam int DIV_C = 4;
    localparam int RW    = DW + 5 + TW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [3:0]    req_op = '0;
    logic [DW-1:0] req_a = '0;
    logic [DW-1:0] req_b = '0;
    logic [TW-1:0] req_tag = '0;
    logic [3:0]    alu_op;
    logic [DW-1:0] alu_a, alu_b, alu_out;
    logic          alu_zero, alu_of, alu_uof;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [DW-1:0] rsp_data;
    logic          rsp_zero, rsp_of, rsp_uof, rsp_dz, rsp_illegal;
    logic [TW-1:0] rsp_tag;
    logic [RW-1:0] rsp_vec;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    alu_issue_ctrl #(
        .DATA_WIDTH (DW),
        .TAG_WIDTH  (TW),
        .MUL_CYCLES (MUL_C),
        .DIV_CYCLES (DIV_C)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_tag     (req_tag),
        .alu_op      (alu_op),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_out     (alu_out),
        .alu_zero    (alu_zero),
        .alu_of      (alu_of),
        .alu_uof     (alu_uof),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .rsp_zero    (rsp_zero),
        .rsp_of      (rsp_of),
        .rsp_uof     (rsp_uof),
        .rsp_dz      (rsp_dz),
        .rsp_illegal (rsp_illegal),
        .rsp_tag     (rsp_tag)
    );

    assign rsp_vec = {rsp_data, rsp_zero, rsp_of, rsp_uof, rsp_dz, rsp_illegal, rsp_tag};

    // Behavioural ALU: {out, zero, of, uof}. Illegal opcodes return junk with
    // flags set so that forcing them to zero is observable.
    function automatic logic [DW+2:0] alu_model(input logic [3:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic [DW-1:0]   r;
        logic            ofl, uofl;
        logic [2*DW-1:0] p;
        logic [2*DW-1:0] sp;
        logic [DW:0]     s;
        r = '0; ofl = 1'b0; uofl = 1'b0;
        case (op)
            4'd0:  r = a << b[4:0];
            4'd1:  r = $signed(a) >>> b[4:0];
            4'd2:  r = a >> b[4:0];
            4'd3: begin
                p    = {{DW{1'b0}}, a} * {{DW{1'b0}}, b};
                sp   = $signed({{DW{a[DW-1]}}, a}) * $signed({{DW{b[DW-1]}}, b});
                r    = p[DW-1:0];
                uofl = |p[2*DW-1:DW];
                ofl  = !((&sp[2*DW-1:DW-1]) || (~|sp[2*DW-1:DW-1]));
            end
            4'd4:  r = (b == 0) ? '1 : a / b;
            4'd5: begin
                s = {1'b0, a} + {1'b0, b}; r = s[DW-1:0]; uofl = s[DW];
                ofl = (a[DW-1] == b[DW-1]) && (r[DW-1] != a[DW-1]);
            end
            4'd6: begin
                s = {1'b0, a} - {1'b0, b}; r = s[DW-1:0]; uofl = s[DW];
                ofl = (a[DW-1] != b[DW-1]) && (r[DW-1] != a[DW-1]);
            end
            4'd7:  r = a & b;
            4'd8:  r = a | b;
            4'd9:  r = a ^ b;
            4'd10: r = ~(a | b);
            4'd11: r = ($signed(a) < $signed(b)) ? 1 : 0;
            4'd12: r = (a < b) ? 1 : 0;
            default: begin r = a + b + 1; ofl = 1'b1; uofl = 1'b1; end
        endcase
        return {r, (r == 0), ofl, uofl};
    endfunction

    assign {alu_out, alu_zero, alu_of, alu_uof} = alu_model(alu_op, alu_a, alu_b);

    // Expected response packed like rsp_vec.
    function automatic logic [RW-1:0] exp_rsp(input logic [3:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [TW-1:0] tag);
        logic [DW+2:0] m;
        logic          dz;
        if (op >= 13) return {{DW{1'b0}}, 4'b0001, tag};
        m  = alu_model(op, a, b);
        dz = (op == 4) && (b == 0);
        return {dz ? {DW{1'b0}} : m[DW+2:3], m[2], m[1], m[0], dz, 1'b0, tag};
    endfunction

    function automatic int exp_lat(input logic [3:0] op);
        if (op == 3) return MUL_C;
        if (op == 4) return DIV_C;
        return 1;
    endfunction

    // Issues one request, checks ALU input stability, latency, payload, and
    // optionally holds rsp_ready low for 'hold' cycles before draining.
    task automatic run_op(input string name, input logic [3:0] op, input logic [DW-1:0] a,
                          input logic [DW-1:0] b, input logic [TW-1:0] tag, input int hold);
        logic [RW-1:0] exp;
        logic [RW-1:0] held;
        int            cyc;
        exp = exp_rsp(op, a, b, tag);
        @(negedge clk);
        req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_tag = tag;
        rsp_ready = (hold == 0);
        #1;
        cyc = 0;
        while (!req_ready && cyc < 20) begin @(negedge clk); #1; cyc++; end
        checks++;
        if (req_ready !== 1'b1) $display("[TB] FAIL %s accept: req_ready=%b required 1", name, req_ready);
        else passes++;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        cyc = 0;
        while (rsp_valid !== 1'b1 && cyc < 40) begin
            checks++;
            if ({alu_op, alu_a, alu_b} !== {op, a, b})
                $display("[TB] FAIL %s alu_hold: got %h/%h/%h required %h/%h/%h", name, alu_op, alu_a, alu_b, op, a, b);
            else passes++;
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (cyc != exp_lat(op)) $display("[TB] FAIL %s latency: got %0d required %0d", name, cyc, exp_lat(op));
        else passes++;
        checks++;
        if (rsp_vec !== exp) $display("[TB] FAIL %s rsp: got %h required %h", name, rsp_vec, exp);
        else passes++;
        held = rsp_vec;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk); #1;
            checks++;
            if ({rsp_valid, req_ready, rsp_vec, alu_op, alu_a, alu_b} !== {1'b1, 1'b0, held, op, a, b})
                $display("[TB] FAIL %s stall%0d: valid=%b ready=%b rsp=%h required 1 0 %h", name, i, rsp_valid, req_ready, rsp_vec, held);
            else passes++;
        end
        rsp_ready = 1'b1;
        @(negedge clk); #1;
        checks++;
        if ({rsp_valid, req_ready} !== 2'b01) $display("[TB] FAIL %s drain: valid/ready=%b%b required 01", name, rsp_valid, req_ready);
        else passes++;
    endtask

    task automatic test_reset;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({req_ready, rsp_valid, rsp_vec, alu_op, alu_a, alu_b} !== '0)
            $display("[TB] FAIL reset_state: ready=%b valid=%b rsp=%h alu_op=%h required all 0", req_ready, rsp_valid, rsp_vec, alu_op);
        else passes++;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if ({req_ready, rsp_valid} !== 2'b10) $display("[TB] FAIL reset_release: ready/valid=%b%b required 10", req_ready, rsp_valid);
        else passes++;
    endtask

    task automatic test_add;     run_op("add", 4'd5, 32'd5, 32'd7, 4'd3, 0); endtask
    task automatic test_div;
        run_op("div", 4'd4, 32'd100, 32'd7, 4'd1, 0);
        run_op("div_zero", 4'd4, 32'd100, 32'd0, 4'd2, 0);
    endtask
    task automatic test_mul;     run_op("mul", 4'd3, 32'h10000, 32'h10000, 4'd4, 0); endtask
    task automatic test_illegal; run_op("illegal", 4'd14, 32'd1, 32'd1, 4'd5, 0); endtask
    task automatic test_stall;   run_op("sub_stall", 4'd6, 32'd3, 32'd5, 4'd6, 5); endtask

    task automatic test_back_to_back;
        int cyc;
        @(negedge clk);
        req_valid = 1'b1; req_op = 4'd6; req_a = 32'd3; req_b = 32'd5; req_tag = 4'd9;
        rsp_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        cyc = 0;
        while (rsp_valid !== 1'b1 && cyc < 20) begin @(negedge clk); cyc++; end
        repeat (5) @(negedge clk);
        checks++;
        if ({rsp_valid, req_ready, rsp_data} !== {1'b1, 1'b0, 32'hFFFF_FFFE})
            $display("[TB] FAIL b2b_hold: valid=%b ready=%b data=%h required 1 0 fffffffe", rsp_valid, req_ready, rsp_data);
        else passes++;
        rsp_ready = 1'b1;
        req_valid = 1'b1; req_op = 4'd5; req_a = 32'd5; req_b = 32'd7; req_tag = 4'd3;
        #1;
        checks++;
        if (req_ready !== 1'b1) $display("[TB] FAIL b2b_ready: req_ready=%b required 1", req_ready);
        else passes++;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        checks++;
        if ({rsp_valid, alu_op, alu_a, alu_b} !== {1'b0, 4'd5, 32'd5, 32'd7})
            $display("[TB] FAIL b2b_accept: valid=%b alu_op=%h a=%h b=%h required 0 5 5 7", rsp_valid, alu_op, alu_a, alu_b);
        else passes++;
        @(negedge clk);
        checks++;
        if ({rsp_valid, rsp_vec} !== {1'b1, exp_rsp(4'd5, 32'd5, 32'd7, 4'd3)})
            $display("[TB] FAIL b2b_rsp: valid=%b rsp=%h required 1 %h", rsp_valid, rsp_vec, exp_rsp(4'd5, 32'd5, 32'd7, 4'd3));
        else passes++;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_div;
        logic seen;
        @(negedge clk);
        req_valid = 1'b1; req_op = 4'd4; req_a = 32'd100; req_b = 32'd7; req_tag = 4'd7;
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({req_ready, rsp_valid, rsp_vec, alu_op, alu_a, alu_b} !== '0)
            $display("[TB] FAIL mid_reset_state: ready=%b valid=%b alu_op=%h alu_a=%h required all 0", req_ready, rsp_valid, alu_op, alu_a);
        else passes++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (req_ready !== 1'b1) $display("[TB] FAIL mid_reset_ready: req_ready=%b required 1", req_ready);
        else passes++;
        seen = 1'b0;
        repeat (8) begin @(negedge clk); if (rsp_valid !== 1'b0) seen = 1'b1; end
        checks++;
        if (seen) $display("[TB] FAIL mid_reset_no_rsp: rsp_valid seen=1 required 0");
        else passes++;
    endtask

    // Random stream against a queue of expected responses.
    task automatic test_random_stream(input string name, input int cycles, input bit full_rate);
        logic [RW-1:0] q[$];
        logic [RW-1:0] exp;
        int            accepts;
        bit            have;
        accepts = 0;
        have    = 1'b0;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            if (!have) begin
                have = full_rate || ($urandom % 3 != 0);
                if (have) begin
                    req_op = 4'($urandom_range(0, 15));
                    if (full_rate) begin
                        req_op = 4'($urandom_range(0, 13));
                        if (req_op >= 3) req_op = req_op + 4'd2;
                    end
                    req_a   = $urandom;
                    req_b   = ($urandom % 5 == 0) ? 32'd0 : $urandom;
                    req_tag = 4'($urandom);
                end
            end
            req_valid = have;
            rsp_ready = full_rate ? 1'b1 : ($urandom % 4 != 0);
            #1;
            if (rsp_valid && rsp_ready) begin
                checks++;
                if (q.size() == 0) $display("[TB] FAIL %s unexpected_rsp: rsp=%h required none", name, rsp_vec);
                else begin
                    exp = q.pop_front();
                    if (rsp_vec !== exp) $display("[TB] FAIL %s rsp: got %h required %h", name, rsp_vec, exp);
                    else passes++;
                end
            end
            if (req_valid && req_ready) begin
                q.push_back(exp_rsp(req_op, req_a, req_b, req_tag));
                accepts++;
                have = 1'b0;
            end
        end
        @(negedge clk);
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        for (int c = 0; c < 50 && q.size() != 0; c++) begin
            #1;
            if (rsp_valid) begin
                checks++;
                exp = q.pop_front();
                if (rsp_vec !== exp) $display("[TB] FAIL %s drain_rsp: got %h required %h", name, rsp_vec, exp);
                else passes++;
            end
            @(negedge clk);
        end
        checks++;
        if (q.size() != 0) $display("[TB] FAIL %s drain: %0d outstanding required 0", name, q.size());
        else passes++;
        if (full_rate) begin
            checks++;
            if (accepts != cycles / 2) $display("[TB] FAIL %s throughput: got %0d accepts required %0d", name, accepts, cycles / 2);
            else passes++;
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset;
        test_add;
        test_div;
        test_mul;
        test_illegal;
        test_stall;
        test_back_to_back;
        test_reset_mid_div;
        test_random_stream("throughput", 40, 1'b1);
        test_random_stream("random", 400, 1'b0);
        $display("[TB] %0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
